// File: rtl/vec_mul_pkg.sv
// Shared types and defaults for the vector-multiply sequencer.
package vec_mul_pkg;

  localparam int ADDRESSSIZE_DEF = 10;
  localparam int LATENCY_DEF     = 34;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    RELOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/vec_mul_sequencer_valid_delay_line.sv
// Fixed-depth 1-bit valid pipe that mirrors the array latency.
// The in_flight flag covers every entry except the one leaving this cycle.
module valid_delay_line #(
  parameter int DEPTH = 34
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout,
  output logic in_flight
);

  logic [DEPTH-1:0] stage;
  logic [DEPTH-1:0] behind;

  // shift a new valid in at the bottom every cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage <= '0;
    end else begin
      stage <= (stage << 1) | DEPTH'(din);
    end
  end

  assign behind    = stage << 1;
  assign in_flight = |behind;
  assign dout      = stage[DEPTH-1];

endmodule

// File: rtl/vec_mul_sequencer.sv
// Control FSM for the 32-lane vector-multiply datapath: weight pop/reload,
// input address streaming, latency-matched result writes and done.
// Optional perf counters are enabled with `define VEC_MUL_SEQ_PERF_EN.
//
// state  | meaning
// IDLE   | waiting for start, job parameters latched on accept
// WLOAD  | pop one weight tile when the FIFO is non-empty
// RELOAD | one-cycle weight reload strobe to the array
// STREAM | one unified-buffer address per cycle
// DRAIN  | wait for the last result write to leave the valid pipe
// DONE   | one-cycle completion pulse
module vec_mul_sequencer
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE = ADDRESSSIZE_DEF,
  parameter int LATENCY     = LATENCY_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] num_vec,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   weight_reload,
  output logic [ADDRESSSIZE-1:0] sram_address,
  output logic                   result_write_enable,
  output logic [ADDRESSSIZE-1:0] sram_result_address,
  output logic                   busy,
  output logic                   done
`ifdef VEC_MUL_SEQ_PERF_EN
  ,
  output logic [31:0]            perf_cycles,
  output logic [15:0]            perf_stall
`endif
);

  state_t state, state_nx;

  logic [ADDRESSSIZE-1:0] rem_q;
  logic [ADDRESSSIZE-1:0] src_q;
  logic [ADDRESSSIZE-1:0] addr_q;
  logic [ADDRESSSIZE-1:0] wr_ptr;
  logic [ADDRESSSIZE-1:0] res_last;
  logic                   pipe_out;
  logic                   in_flight;
  logic                   accept;
  logic                   last_vec;

  assign accept   = (state == IDLE) && start;
  assign last_vec = (rem_q == ADDRESSSIZE'(1));

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state and strobe decode
  always_comb begin
    state_nx         = state;
    fifo_read_enable = 1'b0;
    weight_reload    = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = (num_vec == '0) ? DONE : WLOAD;
        end
      end
      WLOAD: begin
        if (!fifo_empty) begin
          fifo_read_enable = 1'b1;
          state_nx         = RELOAD;
        end
      end
      RELOAD: begin
        weight_reload = 1'b1;
        state_nx      = STREAM;
      end
      STREAM: begin
        if (last_vec) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!in_flight) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // job latches, read address counter and result write pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q    <= '0;
      src_q    <= '0;
      addr_q   <= '0;
      wr_ptr   <= '0;
      res_last <= '0;
    end else begin
      if (accept) begin
        rem_q  <= num_vec;
        src_q  <= src_base;
        wr_ptr <= dst_base;
      end
      if (state == RELOAD) addr_q <= src_q;
      if (state == STREAM) begin
        rem_q <= rem_q - ADDRESSSIZE'(1);
        // keep the final address on the bus once streaming ends
        if (!last_vec) addr_q <= addr_q + ADDRESSSIZE'(1);
      end
      if (pipe_out) begin
        wr_ptr   <= wr_ptr + ADDRESSSIZE'(1);
        res_last <= wr_ptr;
      end
    end
  end

  valid_delay_line #(.DEPTH(LATENCY)) u_valid_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .din       (state == STREAM),
    .dout      (pipe_out),
    .in_flight (in_flight)
  );

  assign sram_address        = addr_q;
  assign result_write_enable = pipe_out;
  assign sram_result_address = pipe_out ? wr_ptr : res_last;

`ifdef VEC_MUL_SEQ_PERF_EN
  logic [31:0] run_q;

  // busy-cycle and weight-stall counters, restarted on each accepted job
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q       <= '0;
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept) begin
        run_q      <= '0;
        perf_stall <= '0;
      end else if (state == DONE) begin
        perf_cycles <= (run_q == '1) ? run_q : run_q + 32'd1;
      end else if (busy) begin
        if (run_q != '1) run_q <= run_q + 32'd1;
        if (state == WLOAD && fifo_empty && perf_stall != '1)
          perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Scoreboard bench for vec_mul_sequencer: job stimulus pushes expected
// events, a negedge monitor pops them as the DUT presents strobes.
module tb_vec_mul_sequencer;

  localparam int AW  = 10;
  localparam int LAT = 34;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] num_vec, src_base, dst_base;
  logic          fifo_empty;
  logic          fifo_read_enable, weight_reload, result_write_enable;
  logic          busy, done;
  logic [AW-1:0] sram_address, sram_result_address;
`ifdef VEC_MUL_SEQ_PERF_EN
  logic [31:0]   perf_cycles;
  logic [15:0]   perf_stall;
`endif

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int pop_q[$], rl_q[$], dn_q[$];
  int rd_cyc[$], rd_adr[$], wr_cyc[$], wr_adr[$];

  vec_mul_sequencer #(.ADDRESSSIZE(AW), .LATENCY(LAT)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .start               (start),
    .num_vec             (num_vec),
    .src_base            (src_base),
    .dst_base            (dst_base),
    .fifo_empty          (fifo_empty),
    .fifo_read_enable    (fifo_read_enable),
    .weight_reload       (weight_reload),
    .sram_address        (sram_address),
    .result_write_enable (result_write_enable),
    .sram_result_address (sram_result_address),
    .busy                (busy),
    .done                (done)
`ifdef VEC_MUL_SEQ_PERF_EN
    ,
    .perf_cycles         (perf_cycles),
    .perf_stall          (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=strobe required=none (cycle %0d)", name, cyc);
  endtask

  function automatic void push_job(input int c0, input int n, input int src,
                                   input int dst, input int s);
    if (n == 0) begin
      dn_q.push_back(c0 + 1);
    end else begin
      pop_q.push_back(c0 + 1 + s);
      rl_q.push_back(c0 + 2 + s);
      for (int i = 0; i < n; i++) begin
        rd_cyc.push_back(c0 + 3 + s + i);
        rd_adr.push_back((src + i) & 'h3FF);
        wr_cyc.push_back(c0 + 3 + s + LAT + i);
        wr_adr.push_back((dst + i) & 'h3FF);
      end
      dn_q.push_back(c0 + n + 3 + LAT + s);
    end
  endfunction

  function automatic void flush_expect();
    pop_q.delete(); rl_q.delete(); dn_q.delete();
    rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete();
  endfunction

  // monitor: compare every strobe against the head of its queue
  always @(negedge clk) begin
    if (fifo_read_enable) begin
      if (pop_q.size() == 0) unexpected("pop");
      else check("pop_cycle", cyc, pop_q.pop_front());
    end
    if (weight_reload) begin
      if (rl_q.size() == 0) unexpected("reload");
      else check("reload_cycle", cyc, rl_q.pop_front());
    end
    if (rd_cyc.size() > 0 && rd_cyc[0] == cyc) begin
      void'(rd_cyc.pop_front());
      check("rd_addr", int'(sram_address), rd_adr.pop_front());
    end
    if (result_write_enable) begin
      if (wr_cyc.size() == 0) unexpected("write");
      else begin
        check("wr_cycle", cyc, wr_cyc.pop_front());
        check("wr_addr", int'(sram_result_address), wr_adr.pop_front());
      end
    end
    if (done) begin
      if (dn_q.size() == 0) unexpected("done");
      else begin
        check("done_cycle", cyc, dn_q.pop_front());
        check("busy_at_done", int'(busy), 1);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int n, input int src, input int dst, input int s);
    int c0;
    next_cycle();
    c0 = cyc;
    push_job(c0, n, src, dst, s);
    start      = 1'b1;
    num_vec    = AW'(n);
    src_base   = AW'(src);
    dst_base   = AW'(dst);
    fifo_empty = (s != 0);
    next_cycle();
    start    = 1'b0;
    num_vec  = '1;
    src_base = 10'h2AA;
    dst_base = 10'h155;
    repeat (s) next_cycle();
    fifo_empty = 1'b0;
    repeat (n + LAT + 8) next_cycle();
  endtask

  initial begin
    int c0;
    rstn = 1'b0; start = 1'b0; num_vec = '0; src_base = '0; dst_base = '0;
    fifo_empty = 1'b0;
    repeat (3) next_cycle();
    check("reset_outputs", int'({fifo_read_enable, weight_reload, result_write_enable,
                                 busy, done, sram_address, sram_result_address}), 0);
    rstn = 1'b1;

    // nominal job
    run_job(4, 'h010, 'h100, 0);
    check("rd_hold", int'(sram_address), 'h013);
    check("wr_hold", int'(sram_result_address), 'h103);

    // weight FIFO stall of 5 cycles
    run_job(4, 'h020, 'h140, 5);
`ifdef VEC_MUL_SEQ_PERF_EN
    check("perf_stall", int'(perf_stall), 5);
    check("perf_cycles", int'(perf_cycles), 46);
`endif

    // zero length
    run_job(0, 'h055, 'h066, 0);
    check("zero_len_rd_hold", int'(sram_address), 'h023);

    // address wrap-around
    run_job(3, 'h3FE, 'h3FF, 0);

    // reset in the middle of a nominal job
    next_cycle();
    c0 = cyc;
    push_job(c0, 4, 'h010, 'h100, 0);
    start = 1'b1; num_vec = 10'd4; src_base = 10'h010; dst_base = 10'h100;
    next_cycle();
    start = 1'b0;
    repeat (19) next_cycle();
    check("busy_before_reset", int'(busy), 1);
    rstn = 1'b0;
    #1;
    check("midjob_reset_outputs", int'({fifo_read_enable, weight_reload, result_write_enable,
                                        busy, done, sram_address, sram_result_address}), 0);
    flush_expect();
    repeat (2) next_cycle();
    rstn = 1'b1;
    repeat (50) next_cycle();
    run_job(4, 'h010, 'h100, 0);

    // back-to-back with start held high
    next_cycle();
    c0 = cyc;
    push_job(c0, 2, 'h030, 'h200, 0);
    push_job(c0 + 2 + 3 + LAT + 1, 2, 'h040, 'h280, 0);
    start = 1'b1; num_vec = 10'd2; src_base = 10'h030; dst_base = 10'h200;
    next_cycle();
    src_base = 10'h040; dst_base = 10'h280;
    repeat (40) next_cycle();
    start = 1'b0;
    repeat (45) next_cycle();

    check("pop_left", pop_q.size(), 0);
    check("reload_left", rl_q.size(), 0);
    check("rd_left", rd_cyc.size(), 0);
    check("wr_left", wr_cyc.size(), 0);
    check("done_left", dn_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
